// File: rtl/hall_meas_scheduler.sv
// hall_meas_scheduler: shares one high/low pulse-width measurement datapath
// across the Hall channels in round-robin order. Each slot measures one full
// high phase and one full low phase of the selected channel, bounded by a
// stalled-rotor timeout, and hands the result downstream over valid/ready.
module hall_meas_scheduler #(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000000
) (
  input  logic              clock_3,
  input  logic              Reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] hall_in,
  input  logic              result_ready,
  output logic              result_valid,
  output logic [1:0]        result_ch,
  output logic [CNT_W-1:0]  result_high,
  output logic [CNT_W-1:0]  result_low,
  output logic              result_timeout,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SELECT    = 3'd1,
    WAIT_RISE = 3'd2,
    MEAS_HIGH = 3'd3,
    MEAS_LOW  = 3'd4,
    PRESENT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       LAST_CH    = 2'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Phase counters stick at all-ones instead of wrapping to a short reading.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [1:0]        ptr_q, ptr_d, ch_q, ch_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              result_valid_q, result_valid_d;
  logic              result_timeout_q, result_timeout_d;
  logic [1:0]        result_ch_q, result_ch_d;
  logic [CNT_W-1:0]  result_high_q, result_high_d, result_low_q, result_low_d;

  // Pad to four lanes so the 2-bit channel index is always a legal select.
  logic [3:0] s_pad, p_pad;
  logic       s_ch, p_ch, rise_ch, fall_ch, timer_done;

  assign s_pad      = 4'(sync2_q);
  assign p_pad      = 4'(hist_q);
  assign s_ch       = s_pad[ch_q];
  assign p_ch       = p_pad[ch_q];
  assign rise_ch    = s_ch & ~p_ch;
  assign fall_ch    = ~s_ch & p_ch;
  assign timer_done = (timer_q == TIMER_LAST);

  // Next-state, counter and result-register logic for the slot scheduler.
  always_comb begin
    state_d          = state_q;
    sync1_d          = hall_in;
    sync2_d          = sync1_q;
    hist_d           = sync2_q;
    ptr_d            = ptr_q;
    ch_d             = ch_q;
    high_cnt_d       = high_cnt_q;
    low_cnt_d        = low_cnt_q;
    timer_d          = timer_q;
    result_valid_d   = result_valid_q;
    result_timeout_d = result_timeout_q;
    result_ch_d      = result_ch_q;
    result_high_d    = result_high_q;
    result_low_d     = result_low_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = SELECT;
      end
      SELECT: begin
        ch_d       = ptr_q;
        ptr_d      = (ptr_q == LAST_CH) ? 2'd0 : ptr_q + 2'd1;
        high_cnt_d = '0;
        low_cnt_d  = '0;
        timer_d    = '0;
        state_d    = enable ? WAIT_RISE : IDLE;
      end
      WAIT_RISE, MEAS_HIGH, MEAS_LOW: begin
        timer_d = timer_q + CNT_ONE;
        if (!enable) begin
          state_d = IDLE;
        end else if (state_q == MEAS_LOW && rise_ch) begin
          // The closing rise completes the slot and wins over an expiring timer.
          result_high_d    = high_cnt_q;
          result_low_d     = low_cnt_q;
          result_ch_d      = ch_q;
          result_timeout_d = 1'b0;
          result_valid_d   = 1'b1;
          state_d          = PRESENT;
        end else if (timer_done) begin
          result_high_d    = high_cnt_q;
          result_low_d     = low_cnt_q;
          result_ch_d      = ch_q;
          result_timeout_d = 1'b1;
          result_valid_d   = 1'b1;
          state_d          = PRESENT;
        end else if (state_q == WAIT_RISE) begin
          if (rise_ch) begin
            high_cnt_d = CNT_ONE;
            state_d    = MEAS_HIGH;
          end
        end else if (state_q == MEAS_HIGH) begin
          if (fall_ch) begin
            low_cnt_d = CNT_ONE;
            state_d   = MEAS_LOW;
          end else if (s_ch) begin
            high_cnt_d = sat_inc(high_cnt_q);
          end
        end else begin
          if (!s_ch) low_cnt_d = sat_inc(low_cnt_q);
        end
      end
      PRESENT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = enable ? SELECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, synchronizer and result registers with synchronous reset.
  always_ff @(posedge clock_3) begin
    if (Reset) begin
      state_q          <= IDLE;
      sync1_q          <= '0;
      sync2_q          <= '0;
      hist_q           <= '0;
      ptr_q            <= '0;
      ch_q             <= '0;
      high_cnt_q       <= '0;
      low_cnt_q        <= '0;
      timer_q          <= '0;
      result_valid_q   <= 1'b0;
      result_timeout_q <= 1'b0;
      result_ch_q      <= '0;
      result_high_q    <= '0;
      result_low_q     <= '0;
    end else begin
      state_q          <= state_d;
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      hist_q           <= hist_d;
      ptr_q            <= ptr_d;
      ch_q             <= ch_d;
      high_cnt_q       <= high_cnt_d;
      low_cnt_q        <= low_cnt_d;
      timer_q          <= timer_d;
      result_valid_q   <= result_valid_d;
      result_timeout_q <= result_timeout_d;
      result_ch_q      <= result_ch_d;
      result_high_q    <= result_high_d;
      result_low_q     <= result_low_d;
    end
  end

  assign result_valid   = result_valid_q;
  assign result_ch      = result_ch_q;
  assign result_high    = result_high_q;
  assign result_low     = result_low_q;
  assign result_timeout = result_timeout_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_hall_meas_scheduler.sv
// tb_hall_meas_scheduler: directed scenarios plus randomized traffic, every
// cycle checked against a sequential behavioural model of the slot scheduler.
`timescale 1ns/1ps
module tb_hall_meas_scheduler;
  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 1000;
  localparam longint MAXC = (longint'(1) << CNT_W) - 1;

  logic              clock_3 = 1'b0;
  logic              Reset = 1'b1;
  logic              enable = 1'b0;
  logic              result_ready = 1'b0;
  logic [NUM_CH-1:0] hall_in = '0;
  logic              result_valid, result_timeout, busy;
  logic [1:0]        result_ch;
  logic [CNT_W-1:0]  result_high, result_low;

  hall_meas_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock_3(clock_3), .Reset(Reset), .enable(enable), .hall_in(hall_in),
    .result_ready(result_ready), .result_valid(result_valid), .result_ch(result_ch),
    .result_high(result_high), .result_low(result_low),
    .result_timeout(result_timeout), .busy(busy)
  );

  always #5 clock_3 = ~clock_3;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clock_3) cyc <= cyc + 1;

  // ---------------- Hall waveform generator ----------------
  // mode 0: periodic wave, 1: stuck high, 2: stuck low, 3: random noise
  int w_mode[NUM_CH] = '{default: 0};
  int w_hi[NUM_CH]   = '{default: 10};
  int w_lo[NUM_CH]   = '{default: 10};
  int w_off[NUM_CH]  = '{default: 0};
  int w_base = 0;

  always @(posedge clock_3) begin
    #2;
    for (int i = 0; i < NUM_CH; i++) begin
      case (w_mode[i])
        1: hall_in[i] = 1'b1;
        2: hall_in[i] = 1'b0;
        3: hall_in[i] = ($urandom_range(0, 1) != 0);
        default: hall_in[i] = (((cyc - w_base + w_off[i]) % (w_hi[i] + w_lo[i])) < w_hi[i]);
      endcase
    end
  end

  // ---------------- Behavioural model ----------------
  logic             exp_valid = 1'b0, exp_to = 1'b0, exp_busy = 1'b0;
  logic [1:0]       exp_ch = '0;
  logic [CNT_W-1:0] exp_high = '0, exp_low = '0;
  bit               model_live = 1'b0;
  int               m_n = 0;
  int               m_ptr = 0;
  int               m_phase = 0;   // 0 waiting for rise, 1 high phase, 2 low phase
  logic [NUM_CH-1:0] samp[4] = '{default: '0};

  // One clock edge as the scheduler sees it: s is the pin value two samples
  // back, p the value three samples back. Reset clears everything.
  task automatic m_tick(output bit r, output bit en, output bit rdy,
                        output logic [NUM_CH-1:0] s, output logic [NUM_CH-1:0] p);
    @(posedge clock_3);
    m_n++;
    r   = Reset;
    en  = enable;
    rdy = result_ready;
    s   = samp[(m_n + 2) % 4];
    p   = samp[(m_n + 1) % 4];
    samp[m_n % 4] = hall_in;
    if (r) begin
      samp[m_n % 4] = '0;
      samp[(m_n + 3) % 4] = '0;
      samp[(m_n + 2) % 4] = '0;
      exp_valid = 1'b0; exp_to = 1'b0; exp_busy = 1'b0;
      exp_ch = '0; exp_high = '0; exp_low = '0;
      m_ptr = 0; m_phase = 0;
      model_live = 1'b1;
    end
  endtask

  task automatic m_present(input int ch, input longint hi, input longint lo, input bit to);
    exp_valid = 1'b1;
    exp_ch    = 2'(ch);
    exp_high  = CNT_W'(hi);
    exp_low   = CNT_W'(lo);
    exp_to    = to;
  endtask

  // Runs slots back to back from SELECT; returns when the scheduler goes idle or resets.
  task automatic run_slots();
    bit r, en, rdy, rise, fall;
    logic [NUM_CH-1:0] s, p;
    int ch;
    longint hi, lo, t;
    bit done;
    exp_busy = 1'b1;
    forever begin
      m_tick(r, en, rdy, s, p);
      if (r) return;
      ch = m_ptr;
      m_ptr = (m_ptr + 1) % NUM_CH;
      if (!en) begin exp_busy = 1'b0; return; end
      hi = 0; lo = 0; t = 0; m_phase = 0; done = 1'b0;
      while (!done) begin
        m_tick(r, en, rdy, s, p);
        if (r) return;
        if (!en) begin exp_busy = 1'b0; m_phase = 0; return; end
        rise = s[ch] && !p[ch];
        fall = !s[ch] && p[ch];
        if (m_phase == 2 && rise) begin
          m_present(ch, hi, lo, 1'b0); done = 1'b1;
        end else if (t == TIMEOUT - 1) begin
          m_present(ch, hi, lo, 1'b1); done = 1'b1;
        end else if (m_phase == 0) begin
          if (rise) begin hi = 1; m_phase = 1; end
        end else if (m_phase == 1) begin
          if (fall) begin lo = 1; m_phase = 2; end
          else if (s[ch]) hi = (hi >= MAXC) ? MAXC : hi + 1;
        end else begin
          if (!s[ch]) lo = (lo >= MAXC) ? MAXC : lo + 1;
        end
        t++;
      end
      m_phase = 0;
      do begin
        m_tick(r, en, rdy, s, p);
        if (r) return;
      end while (!rdy);
      exp_valid = 1'b0;
      if (!en) begin exp_busy = 1'b0; return; end
    end
  endtask

  initial begin : model
    bit r, en, rdy;
    logic [NUM_CH-1:0] s, p;
    forever begin
      m_tick(r, en, rdy, s, p);
      if (!r && en) run_slots();
    end
  end

  // ---------------- Per-cycle comparison against the model ----------------
  always @(negedge clock_3) begin
    if (model_live) begin
      n_cmp++;
      if ({result_valid, result_ch, result_high, result_low, result_timeout, busy} !==
          {exp_valid, exp_ch, exp_high, exp_low, exp_to, exp_busy}) begin
        n_bad++;
        $display("FAIL cycle_outputs @%0d: got v=%0b ch=%0d hi=%0d lo=%0d to=%0b busy=%0b, want v=%0b ch=%0d hi=%0d lo=%0d to=%0b busy=%0b",
                 cyc, result_valid, result_ch, result_high, result_low, result_timeout, busy,
                 exp_valid, exp_ch, exp_high, exp_low, exp_to, exp_busy);
      end
    end
  end

  // ---------------- Result log ----------------
  typedef struct {
    int     ch;
    longint hi;
    longint lo;
    bit     to;
    int     rise;
    int     hs;
    int     width;
  } rec_t;
  rec_t res_q[$];
  int vrun = 0;
  int vrise = 0;

  always @(negedge clock_3) begin
    rec_t tmp;
    if (result_valid === 1'b1) begin
      if (vrun == 0) vrise = cyc;
      vrun++;
      if (result_ready === 1'b1) begin
        tmp.ch = int'(result_ch); tmp.hi = longint'(result_high); tmp.lo = longint'(result_low);
        tmp.to = result_timeout; tmp.rise = vrise; tmp.hs = cyc; tmp.width = vrun;
        res_q.push_back(tmp);
      end
    end else begin
      vrun = 0;
    end
  end

  // ---------------- Helpers ----------------
  task automatic chk(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cyc_wait(input int k);
    repeat (k) begin
      @(posedge clock_3);
      #2;
    end
  endtask

  task automatic set_wave(input int i, input int m, input int h, input int l, input int o);
    w_mode[i] = m; w_hi[i] = h; w_lo[i] = l; w_off[i] = o;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    Reset = 1'b1;
    cyc_wait(2);
    Reset = 1'b0;
    res_q.delete();
  endtask

  task automatic wait_res(input int n, input int budget, input string name, output bit ok);
    int k = 0;
    while (res_q.size() < n && k < budget) begin
      cyc_wait(1);
      k++;
    end
    ok = (res_q.size() >= n);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: waited %0d cycles, got %0d results want %0d", name, budget, res_q.size(), n);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ch"}, result_ch, 0);
    chk({tag, "_high"}, result_high, 0);
    chk({tag, "_low"}, result_low, 0);
    chk({tag, "_timeout"}, result_timeout, 0);
  endtask

  // ---------------- Scenarios ----------------
  initial begin : main
    bit ok;
    int k;
    int exp_seq[4] = '{0, 1, 2, 0};
    logic [1:0] cap_ch;
    logic [CNT_W-1:0] cap_hi, cap_lo;
    logic cap_to;

    set_wave(0, 0, 50, 30, 0);
    set_wave(1, 0, 70, 40, 13);
    set_wave(2, 0, 90, 60, 37);
    w_base = 0;
    cyc_wait(3);
    Reset = 1'b0;
    cyc_wait(1);
    chk_zero_outputs("reset");

    // Basic measurement and round-robin order
    enable = 1'b1;
    result_ready = 1'b1;
    wait_res(4, 5000, "rr_wait", ok);
    if (ok) begin
      chk("first_width", res_q[0].width, 1);
      for (int i = 0; i < 4; i++) begin
        chk("rr_ch", res_q[i].ch, exp_seq[i]);
        chk("rr_high", res_q[i].hi, w_hi[exp_seq[i]]);
        chk("rr_low", res_q[i].lo, w_lo[exp_seq[i]]);
        chk("rr_timeout", res_q[i].to, 0);
      end
      chk("first_high_50", res_q[0].hi, 50);
      chk("first_low_30", res_q[0].lo, 30);
    end

    // Backpressure
    do_reset();
    result_ready = 1'b0;
    enable = 1'b1;
    k = 0;
    while (result_valid !== 1'b1 && k < 2000) begin cyc_wait(1); k++; end
    chk("bp_valid_seen", result_valid, 1);
    cap_ch = result_ch; cap_hi = result_high; cap_lo = result_low; cap_to = result_timeout;
    for (int i = 0; i < 20; i++) begin
      cyc_wait(1);
      chk("bp_valid_hold", result_valid, 1);
      chk("bp_ch_hold", result_ch, cap_ch);
      chk("bp_high_hold", result_high, cap_hi);
      chk("bp_low_hold", result_low, cap_lo);
      chk("bp_timeout_hold", result_timeout, cap_to);
    end
    result_ready = 1'b1;
    cyc_wait(1);
    chk("bp_valid_drop", result_valid, 0);
    chk("bp_busy_select", busy, 1);
    wait_res(2, 3000, "bp_wait", ok);
    if (ok) begin
      chk("bp_first_ch", res_q[0].ch, 0);
      chk("bp_width_ge21", (res_q[0].width >= 21) ? 1 : 0, 1);
      chk("bp_next_ch", res_q[1].ch, 1);
    end

    // Stuck-high channel times out in WAIT_RISE
    set_wave(1, 1, 70, 40, 0);
    do_reset();
    result_ready = 1'b1;
    enable = 1'b1;
    wait_res(3, 5000, "to_wait", ok);
    if (ok) begin
      chk("to_first_ch", res_q[0].ch, 0);
      chk("to_ch", res_q[1].ch, 1);
      chk("to_flag", res_q[1].to, 1);
      chk("to_high", res_q[1].hi, 0);
      chk("to_low", res_q[1].lo, 0);
      chk("to_latency", res_q[1].rise - res_q[0].hs, TIMEOUT + 2);
      chk("to_next_ch", res_q[2].ch, 2);
      chk("to_next_flag", res_q[2].to, 0);
    end

    // Timeout in the middle of a long high phase
    set_wave(0, 0, 2000, 40, 2000);
    set_wave(1, 0, 70, 40, 13);
    w_base = cyc;
    do_reset();
    enable = 1'b1;
    wait_res(1, 3000, "ph_wait", ok);
    if (ok) begin
      chk("ph_ch", res_q[0].ch, 0);
      chk("ph_flag", res_q[0].to, 1);
      chk("ph_high_lt_to", (res_q[0].hi < TIMEOUT) ? 1 : 0, 1);
      chk("ph_high_gt0", (res_q[0].hi > 0) ? 1 : 0, 1);
      chk("ph_low", res_q[0].lo, 0);
    end

    // Reset in MEAS_LOW
    set_wave(0, 0, 50, 30, 0);
    w_base = cyc;
    do_reset();
    enable = 1'b1;
    k = 0;
    while (m_phase != 2 && k < 2000) begin cyc_wait(1); k++; end
    chk("rs_reached_low", m_phase, 2);
    Reset = 1'b1;
    cyc_wait(1);
    chk_zero_outputs("rs_after");
    Reset = 1'b0;
    enable = 1'b0;
    res_q.delete();
    cyc_wait(4);
    chk("rs_idle_busy", busy, 0);
    enable = 1'b1;
    wait_res(1, 3000, "rs_wait", ok);
    if (ok) chk("rs_first_ch", res_q[0].ch, 0);

    // Randomized traffic
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int i = 0; i < NUM_CH; i++)
        set_wave(i, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                 int'($urandom_range(1, 80)), int'($urandom_range(1, 80)),
                 int'($urandom_range(0, 159)));
      w_base = cyc;
      for (int c = 0; c < 2500; c++) begin
        Reset        = ($urandom_range(0, 1199) == 0);
        enable       = ($urandom_range(0, 149) != 0);
        result_ready = ($urandom_range(0, 3) != 0);
        cyc_wait(1);
      end
    end
    Reset = 1'b0;
    enable = 1'b0;
    result_ready = 1'b1;
    cyc_wait(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hall_meas_scheduler.md
Name: hall_meas_scheduler

Overview:
- Time-shares one high/low pulse-width measurement datapath across the three Hall sensor channels (SA, SB, SC) in round-robin order.
- Each slot measures one full high phase and one full low phase of the selected channel.
- A stalled-rotor timeout bounds each slot.
- Results go to the speed/closed-loop logic over a valid/ready handshake.

Parameters:
NUM_CH, 3, number of Hall channels; legal range 2..4.
CNT_W, 32, width of the high/low counters and the timeout timer.
TIMEOUT, 100000000, per-slot limit in clock_3 cycles (1 s at 100 MHz); must be at least 4.

Ports:
clock_3  input  1  100 MHz system clock.
Reset  input  1  Synchronous, active-high reset, sampled on the rising edge of clock_3.
enable  input  1  Runs the scheduler when high.
hall_in  input  NUM_CH  Raw asynchronous Hall signals; bit0=SA, bit1=SB, bit2=SC.
result_ready  input  1  Downstream accepts the result.
result_valid  output  1  Result registers hold a valid measurement.
result_ch  output  2  Channel index of the result.
result_high  output  CNT_W  High-phase duration in cycles.
result_low  output  CNT_W  Low-phase duration in cycles.
result_timeout  output  1  Slot ended by timeout; counts are partial.
busy  output  1  FSM is not in IDLE.

Behaviour:
Reset (synchronous):
- FSM goes to IDLE.
- Round-robin pointer is 0.
- All counters, synchronizer flops and the edge-history flop are 0.
- result_valid, result_ch, result_high, result_low, result_timeout and busy are all 0.
- Reset overrides every other condition in the same cycle, including mid-measurement and mid-handshake; an aborted slot produces no result.

Input conditioning:
- Each hall_in bit passes through a 2-flop synchronizer, giving s[i].
- A free-running history flop p[i] holds s[i] from the previous cycle.
- Rise = s & ~p; fall = ~s & p.
- Latency from pin to edge detection is 3 cycles.

FSM states:
- IDLE: busy=0. If enable=1, go to SELECT.
- SELECT (1 cycle): ch <= pointer; pointer <= (pointer==NUM_CH-1) ? 0 : pointer+1; clear high_cnt, low_cnt and timer. Go to WAIT_RISE.
- WAIT_RISE: wait for a rise on channel ch.
  - A level that is already high at SELECT is not an edge.
  - On rise: high_cnt <= 1, go to MEAS_HIGH.
- MEAS_HIGH: high_cnt increments each cycle while s[ch]=1.
  - On fall: low_cnt <= 1, go to MEAS_LOW.
- MEAS_LOW: low_cnt increments each cycle while s[ch]=0.
  - On rise: load result_high and result_low, result_ch <= ch, result_timeout <= 0. Go to PRESENT.
  - The closing rise is not counted in either phase.
- Count definition: a clean wave with H high and L low synchronized cycles yields result_high=H and result_low=L exactly.

Timeout:
- timer increments in WAIT_RISE, MEAS_HIGH and MEAS_LOW.
- When timer == TIMEOUT-1 and no completing edge occurs that cycle: load the current partial counts, result_timeout <= 1, go to PRESENT.
- A completing rise in the same cycle as timer expiry wins; the result is normal with timeout=0.

Counters:
- high_cnt and low_cnt saturate at all-ones and never wrap.

Abort:
- enable=0 in SELECT, WAIT_RISE, MEAS_HIGH or MEAS_LOW: go to IDLE next cycle, no result produced.
- The pointer keeps the value already advanced in SELECT.

PRESENT:
- result_valid=1 and all result_* are held stable until result_valid && result_ready is seen at a clock edge.
- On that handshake: result_valid <= 0. Go to SELECT if enable=1, otherwise IDLE.
- enable has no effect while in PRESENT.
- result_* keep their last values after the handshake; only result_valid drops.

busy:
- 1 in every state except IDLE.

Test Plan:
- Square wave on SA, high 50 / low 30 cycles; enable=1; result_ready=1; SB and SC toggle slowly. Required: first result result_ch=0, result_high=50, result_low=30, result_timeout=0; result_valid high for exactly 1 cycle.
- All three channels toggling, 4 handshakes. Required: result_ch sequence 0,1,2,0, each with correct counts for its own channel waveform.
- Backpressure: result_ready held low for 20 cycles after result_valid rises. Required: result_valid and all result_* stable for 20 cycles; no channel advance; SELECT entered the cycle after ready rises.
- TIMEOUT=1000; SB stuck high, so no rise occurs in its slot. Required: result_valid exactly 1000 cycles after SELECT, result_ch=1, result_timeout=1, result_high=0, result_low=0. Next slot is channel 2.
- Timeout during a phase, TIMEOUT=1000, SA high for 2000 cycles. Required: result_timeout=1, result_high equal to the partial high count (under 1000), result_low=0.
- Reset asserted for 1 cycle in MEAS_LOW, then enable=0, then enable=1. Required: the cycle after Reset shows result_valid=0, busy=0 and all outputs 0; the first slot after re-enable measures channel 0.
